// File: rtl/slc3_datapath_p_if.sv
// slc3_datapath_p_if
// Groups the SLC-3 datapath control inputs, memory read data and
// architectural outputs into one bundle.
//   master : control unit / bench side (drives loads, gates, mux selects, MDR_In)
//   slave  : datapath side (drives IR, PC, MAR, MDR, LED, NZP, BEN, bus_conflict)
// Parameters: DATA_W (bus width, >=16), LED_W (LED width, <=16).
interface slc3_datapath_p_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LED_W  = 10
);
    // Register load enables
    logic              LD_REG;
    logic              LD_PC;
    logic              LD_MDR;
    logic              LD_MAR;
    logic              LD_IR;
    logic              LD_LED;
    logic              LD_CC;
    logic              LD_BEN;
    // Bus drive selects
    logic              GatePC;
    logic              GateMDR;
    logic              GateALU;
    logic              GateMARMUX;
    // Mux selects
    logic [1:0]        PCMUX;
    logic [1:0]        ADDR2MUX;
    logic [1:0]        ALUK;
    logic              DRMUX;
    logic              SR1MUX;
    logic              SR2MUX;
    logic              ADDR1MUX;
    // Memory side
    logic              MIO_EN;
    logic [DATA_W-1:0] MDR_In;
    // Architectural outputs
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] MAR;
    logic [DATA_W-1:0] MDR;
    logic [LED_W-1:0]  LED;
    logic [2:0]        NZP;
    logic              BEN;
    logic              bus_conflict;

    modport master (
        output LD_REG, LD_PC, LD_MDR, LD_MAR, LD_IR, LD_LED, LD_CC, LD_BEN,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
        output MIO_EN, MDR_In,
        input  IR, PC, MAR, MDR, LED, NZP, BEN, bus_conflict
    );

    modport slave (
        input  LD_REG, LD_PC, LD_MDR, LD_MAR, LD_IR, LD_LED, LD_CC, LD_BEN,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
        input  MIO_EN, MDR_In,
        output IR, PC, MAR, MDR, LED, NZP, BEN, bus_conflict
    );
endinterface

// File: rtl/slc3_datapath_p.sv
// slc3_datapath_p
// Parametrised SLC-3 datapath: 8-entry register file, 4-op ALU, address adder
// feeding MARMUX/PCMUX, NZP condition codes, BEN register and a prioritised
// internal bus (PC > MDR > ALU > MARMUX, zero when nothing is gated).
// Ports:
//   Clk   : system clock, rising edge
//   Reset : asynchronous active-high reset
//   dp    : slc3_datapath_p_if.slave (controls, MDR_In, architectural outputs)
// Parameters: DATA_W (>=16), LED_W (<=16), PC_RESET.
// Optional feature: define SLC3_BUS_CONFLICT_EN to build the sticky
// bus_conflict detector; otherwise bus_conflict is tied to 0.
module slc3_datapath_p #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       LED_W    = 10,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input logic                Clk,
    input logic                Reset,
    slc3_datapath_p_if.slave   dp
);

    logic [DATA_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [2:0]        nzp_q, nzp_d;
    logic              ben_q, ben_d;
    logic [DATA_W-1:0] rf_q [8];

    logic [2:0]        dr_sel;
    logic [2:0]        sr1_sel;
    logic [2:0]        sr2_sel;
    logic [DATA_W-1:0] sr1_val;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] addr_sum;
    logic [DATA_W-1:0] bus_w;

    // Opcode bits are decoded by the control unit, not here.
    logic unused_ir;
    assign unused_ir = ^ir_q[DATA_W-1:12];

    // Operand / destination selection; reads see pre-edge register contents.
    always_comb begin
        dr_sel  = dp.DRMUX  ? 3'd7       : ir_q[11:9];
        sr1_sel = dp.SR1MUX ? ir_q[8:6]  : ir_q[11:9];
        sr2_sel = ir_q[2:0];
        sr1_val = rf_q[sr1_sel];
        alu_b   = dp.SR2MUX ? {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]} : rf_q[sr2_sel];
    end

    always_comb begin
        unique case (dp.ALUK)
            2'b00:   alu_out = sr1_val + alu_b;
            2'b01:   alu_out = sr1_val & alu_b;
            2'b10:   alu_out = ~sr1_val;
            default: alu_out = sr1_val;
        endcase
    end

    always_comb begin
        addr1 = dp.ADDR1MUX ? sr1_val : pc_q;
        unique case (dp.ADDR2MUX)
            2'b00:   addr2 = '0;
            2'b01:   addr2 = {{(DATA_W-6){ir_q[5]}},  ir_q[5:0]};
            2'b10:   addr2 = {{(DATA_W-9){ir_q[8]}},  ir_q[8:0]};
            default: addr2 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};
        endcase
        addr_sum = addr1 + addr2;
    end

    // Bus priority resolves multi-gate cycles deterministically.
    always_comb begin
        if (dp.GatePC) begin
            bus_w = pc_q;
        end else if (dp.GateMDR) begin
            bus_w = mdr_q;
        end else if (dp.GateALU) begin
            bus_w = alu_out;
        end else if (dp.GateMARMUX) begin
            bus_w = addr_sum;
        end else begin
            bus_w = '0;
        end
    end

    // Next-state for the architectural registers.
    always_comb begin
        pc_d = pc_q;
        if (dp.LD_PC) begin
            unique case (dp.PCMUX)
                2'b00:   pc_d = pc_q + DATA_W'(1);
                2'b01:   pc_d = bus_w;
                2'b10:   pc_d = addr_sum;
                default: pc_d = pc_q;
            endcase
        end

        ir_d  = dp.LD_IR  ? bus_w : ir_q;
        mar_d = dp.LD_MAR ? bus_w : mar_q;
        mdr_d = mdr_q;
        if (dp.LD_MDR) begin
            mdr_d = dp.MIO_EN ? dp.MDR_In : bus_w;
        end

        nzp_d = nzp_q;
        if (dp.LD_CC) begin
            if (bus_w[DATA_W-1]) begin
                nzp_d = 3'b100;
            end else if (bus_w == '0) begin
                nzp_d = 3'b010;
            end else begin
                nzp_d = 3'b001;
            end
        end

        // BEN samples the old NZP even when LD_CC fires in the same cycle.
        ben_d = dp.LD_BEN ? |(ir_q[11:9] & nzp_q) : ben_q;

        // LED is a one-cycle pulse of the IR low bits, cleared when not loaded.
        led_d = dp.LD_LED ? ir_q[LED_W-1:0] : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q  <= PC_RESET;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            led_q <= '0;
            nzp_q <= 3'b000;
            ben_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            led_q <= led_d;
            nzp_q <= nzp_d;
            ben_q <= ben_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (dp.LD_REG) begin
            rf_q[dr_sel] <= bus_w;
        end
    end

`ifdef SLC3_BUS_CONFLICT_EN
    logic conflict_q;
    logic multi_gate;

    // True when any two gates are asserted together.
    assign multi_gate = (dp.GatePC  & (dp.GateMDR | dp.GateALU | dp.GateMARMUX)) |
                        (dp.GateMDR & (dp.GateALU | dp.GateMARMUX)) |
                        (dp.GateALU & dp.GateMARMUX);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            conflict_q <= 1'b0;
        end else if (multi_gate) begin
            conflict_q <= 1'b1;
        end
    end

    assign dp.bus_conflict = conflict_q;
`else
    assign dp.bus_conflict = 1'b0;
`endif

    assign dp.PC  = pc_q;
    assign dp.IR  = ir_q;
    assign dp.MAR = mar_q;
    assign dp.MDR = mdr_q;
    assign dp.LED = led_q;
    assign dp.NZP = nzp_q;
    assign dp.BEN = ben_q;

endmodule

// File: tb/tb_slc3_datapath_p.sv
// tb_slc3_datapath_p
// Directed bench for slc3_datapath_p with an architectural reference model
// compared on every falling clock edge, plus literal expectations.
module tb_slc3_datapath_p;

    localparam int unsigned DW = 16;
    localparam int unsigned LW = 10;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    bit   run   = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef SLC3_BUS_CONFLICT_EN
    localparam bit ConflictOn = 1'b1;
`else
    localparam bit ConflictOn = 1'b0;
`endif

    always #5 Clk = ~Clk;

    slc3_datapath_p_if #(.DATA_W(DW), .LED_W(LW)) dp_if ();

    slc3_datapath_p #(.DATA_W(DW), .LED_W(LW), .PC_RESET(16'h0000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .dp    (dp_if.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_pc, m_ir, m_mar, m_mdr;
    logic [15:0] m_r [8];
    logic [2:0]  m_nzp;
    logic        m_ben, m_cf;
    logic [9:0]  m_led;

    function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
        logic [15:0] m;
        m = (16'h1 << bits) - 16'h1;
        return v[bits-1] ? ((v & m) | ~m) : (v & m);
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pc = 16'h0; m_ir = 16'h0; m_mar = 16'h0; m_mdr = 16'h0;
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
            m_nzp = 3'b000; m_ben = 1'b0; m_led = '0; m_cf = 1'b0;
        end else begin
            logic [15:0] a, b, alu, adr, bus, npc;
            logic [2:0]  nnzp;
            int          ngates;
            a = m_r[dp_if.SR1MUX ? int'(m_ir[8:6]) : int'(m_ir[11:9])];
            b = dp_if.SR2MUX ? sx(m_ir, 5) : m_r[m_ir[2:0]];
            case (dp_if.ALUK)
                2'd0: alu = a + b;
                2'd1: alu = a & b;
                2'd2: alu = ~a;
                default: alu = a;
            endcase
            adr = dp_if.ADDR1MUX ? a : m_pc;
            case (dp_if.ADDR2MUX)
                2'd0: adr = adr;
                2'd1: adr = adr + sx(m_ir, 6);
                2'd2: adr = adr + sx(m_ir, 9);
                default: adr = adr + sx(m_ir, 11);
            endcase
            ngates = int'(dp_if.GatePC) + int'(dp_if.GateMDR) + int'(dp_if.GateALU)
                     + int'(dp_if.GateMARMUX);
            if (dp_if.GatePC) bus = m_pc;
            else if (dp_if.GateMDR) bus = m_mdr;
            else if (dp_if.GateALU) bus = alu;
            else if (dp_if.GateMARMUX) bus = adr;
            else bus = 16'h0;
            case (dp_if.PCMUX)
                2'd0: npc = m_pc + 16'h1;
                2'd1: npc = bus;
                2'd2: npc = adr;
                default: npc = m_pc;
            endcase
            nnzp = ($signed(bus) < 0) ? 3'b100 : (bus == 0 ? 3'b010 : 3'b001);
            if (dp_if.LD_BEN) m_ben = (m_ir[11:9] & m_nzp) != 0;
            if (dp_if.LD_CC)  m_nzp = nnzp;
            m_led = dp_if.LD_LED ? m_ir[9:0] : 10'h0;
            if (dp_if.LD_REG) m_r[dp_if.DRMUX ? 7 : int'(m_ir[11:9])] = bus;
            if (dp_if.LD_PC)  m_pc = npc;
            if (dp_if.LD_MAR) m_mar = bus;
            if (dp_if.LD_IR)  m_ir = bus;
            if (dp_if.LD_MDR) m_mdr = dp_if.MIO_EN ? dp_if.MDR_In : bus;
            if (ngates > 1 && ConflictOn) m_cf = 1'b1;
        end
    end

    always @(negedge Clk) begin
        if (run) begin
            chk("model_PC",  32'(dp_if.PC),  32'(m_pc));
            chk("model_IR",  32'(dp_if.IR),  32'(m_ir));
            chk("model_MAR", 32'(dp_if.MAR), 32'(m_mar));
            chk("model_MDR", 32'(dp_if.MDR), 32'(m_mdr));
            chk("model_LED", 32'(dp_if.LED), 32'(m_led));
            chk("model_NZP", 32'(dp_if.NZP), 32'(m_nzp));
            chk("model_BEN", 32'(dp_if.BEN), 32'(m_ben));
            chk("model_CF",  32'(dp_if.bus_conflict), 32'(m_cf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clr();
        dp_if.LD_REG = 0; dp_if.LD_PC = 0; dp_if.LD_MDR = 0; dp_if.LD_MAR = 0;
        dp_if.LD_IR = 0; dp_if.LD_LED = 0; dp_if.LD_CC = 0; dp_if.LD_BEN = 0;
        dp_if.GatePC = 0; dp_if.GateMDR = 0; dp_if.GateALU = 0; dp_if.GateMARMUX = 0;
        dp_if.PCMUX = 2'd0; dp_if.ADDR2MUX = 2'd0; dp_if.ALUK = 2'd0;
        dp_if.DRMUX = 0; dp_if.SR1MUX = 0; dp_if.SR2MUX = 0; dp_if.ADDR1MUX = 0;
        dp_if.MIO_EN = 0; dp_if.MDR_In = 16'h0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        clr();
    endtask

    task automatic load_mdr(input logic [15:0] v);
        dp_if.MIO_EN = 1; dp_if.LD_MDR = 1; dp_if.MDR_In = v;
        tick();
    endtask

    task automatic load_ir(input logic [15:0] v);
        load_mdr(v);
        dp_if.GateMDR = 1; dp_if.LD_IR = 1;
        tick();
    endtask

    task automatic load_pc(input logic [15:0] v);
        load_mdr(v);
        dp_if.GateMDR = 1; dp_if.LD_PC = 1; dp_if.PCMUX = 2'd1;
        tick();
    endtask

    task automatic set_reg(input int n, input logic [15:0] v);
        logic [15:0] irv;
        irv = 16'(n) << 9;
        load_ir(irv);
        load_mdr(v);
        dp_if.GateMDR = 1; dp_if.LD_REG = 1;
        tick();
    endtask

    initial begin
        logic [15:0] alu_exp [4];
        logic [15:0] adr_exp [4];
        alu_exp[0] = 16'h8F11; alu_exp[1] = 16'h0002;
        alu_exp[2] = 16'h7FFD; alu_exp[3] = 16'h8002;
        adr_exp[0] = 16'h8002; adr_exp[1] = 16'h8007;
        adr_exp[2] = 16'h8087; adr_exp[3] = 16'h8287;

        clr();
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst_PC", 32'(dp_if.PC), 32'h0);
        chk("rst_NZP", 32'(dp_if.NZP), 32'h0);
        chk("rst_CF", 32'(dp_if.bus_conflict), 32'h0);
        Reset = 1'b0;
        run = 1'b1;

        // Asynchronous reset mid-operation
        load_pc(16'h0042);
        set_reg(3, 16'h1234);
        chk("pre_rst_PC", 32'(dp_if.PC), 32'h0042);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_PC", 32'(dp_if.PC), 32'h0);
        chk("async_rst_NZP", 32'(dp_if.NZP), 32'h0);
        chk("async_rst_LED", 32'(dp_if.LED), 32'h0);
        chk("async_rst_IR", 32'(dp_if.IR), 32'h0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        load_ir(16'h0600);
        dp_if.GateALU = 1; dp_if.ALUK = 2'd3; dp_if.LD_MAR = 1;
        tick();
        chk("rst_R3", 32'(dp_if.MAR), 32'h0);

        // Fetch
        load_pc(16'h0005);
        dp_if.GatePC = 1; dp_if.LD_MAR = 1; dp_if.LD_PC = 1; dp_if.PCMUX = 2'd0;
        tick();
        chk("fetch_MAR", 32'(dp_if.MAR), 32'h0005);
        chk("fetch_PC", 32'(dp_if.PC), 32'h0006);
        load_mdr(16'h1283);
        chk("fetch_MDR", 32'(dp_if.MDR), 32'h1283);
        dp_if.GateMDR = 1; dp_if.LD_IR = 1;
        tick();
        chk("fetch_IR", 32'(dp_if.IR), 32'h1283);

        // ADD immediate with overflow into the sign bit
        set_reg(2, 16'h7FFF);
        load_ir(16'h1483);
        dp_if.SR1MUX = 1; dp_if.SR2MUX = 1; dp_if.GateALU = 1; dp_if.ALUK = 2'd0;
        dp_if.LD_REG = 1; dp_if.LD_CC = 1;
        tick();
        chk("add_NZP", 32'(dp_if.NZP), 32'h4);
        dp_if.SR1MUX = 1; dp_if.GateALU = 1; dp_if.ALUK = 2'd3; dp_if.LD_MAR = 1;
        tick();
        chk("add_R2", 32'(dp_if.MAR), 32'h8002);

        // ALU ops and address adder offsets, R2=0x8002, R5=0x0F0F, IR=0x5285
        set_reg(5, 16'h0F0F);
        load_ir(16'h5285);
        for (int k = 0; k < 4; k++) begin
            dp_if.SR1MUX = 1; dp_if.ALUK = 2'(k); dp_if.GateALU = 1;
            dp_if.LD_MAR = 1; dp_if.LD_CC = 1;
            tick();
            chk("alu_op", 32'(dp_if.MAR), 32'(alu_exp[k]));
        end
        for (int k = 0; k < 4; k++) begin
            dp_if.SR1MUX = 1; dp_if.ADDR1MUX = 1; dp_if.ADDR2MUX = 2'(k);
            dp_if.GateMARMUX = 1; dp_if.LD_MAR = 1;
            tick();
            chk("marmux", 32'(dp_if.MAR), 32'(adr_exp[k]));
        end

        // Branch BRz -3
        load_mdr(16'h0000);
        dp_if.GateMDR = 1; dp_if.LD_CC = 1;
        tick();
        chk("br_NZP", 32'(dp_if.NZP), 32'h2);
        load_ir(16'h05FD);
        dp_if.LD_BEN = 1;
        tick();
        chk("br_BEN", 32'(dp_if.BEN), 32'h1);
        load_pc(16'h0010);
        dp_if.ADDR1MUX = 0; dp_if.ADDR2MUX = 2'd2; dp_if.PCMUX = 2'd2; dp_if.LD_PC = 1;
        tick();
        chk("br_PC", 32'(dp_if.PC), 32'h000D);

        // LD_CC and LD_BEN together: BEN sees old NZP (010) against IR[11:9]=001
        load_ir(16'h0200);
        load_mdr(16'h0005);
        dp_if.GateMDR = 1; dp_if.LD_CC = 1; dp_if.LD_BEN = 1;
        tick();
        chk("ccben_NZP", 32'(dp_if.NZP), 32'h1);
        chk("ccben_BEN", 32'(dp_if.BEN), 32'h0);
        dp_if.LD_BEN = 1;
        tick();
        chk("ben_new", 32'(dp_if.BEN), 32'h1);

        // LED pulse
        load_ir(16'h03FF);
        dp_if.LD_LED = 1;
        tick();
        chk("led_on", 32'(dp_if.LED), 32'h3FF);
        tick();
        chk("led_off", 32'(dp_if.LED), 32'h0);

        // PC wrap
        load_pc(16'hFFFF);
        dp_if.LD_PC = 1; dp_if.PCMUX = 2'd0;
        tick();
        chk("pc_wrap", 32'(dp_if.PC), 32'h0);

        // Bus conflict: PC wins the bus
        load_pc(16'h0003);
        load_mdr(16'h00FF);
        chk("pre_conf_CF", 32'(dp_if.bus_conflict), 32'h0);
        dp_if.GatePC = 1; dp_if.GateMDR = 1; dp_if.LD_MAR = 1;
        tick();
        chk("conf_MAR", 32'(dp_if.MAR), 32'h0003);
        chk("conf_CF", 32'(dp_if.bus_conflict), 32'(ConflictOn));
        tick();
        tick();
        chk("conf_sticky", 32'(dp_if.bus_conflict), 32'(ConflictOn));
        #2 Reset = 1'b1;
        #1;
        chk("conf_reset", 32'(dp_if.bus_conflict), 32'h0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        tick();
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/slc3_datapath_p.md
Name:
slc3_datapath_p

Overview:
- Parametrised SLC-3 datapath: the successor to the fetch-only datapath.
- Adds an 8-entry register file, a 4-op ALU, an address adder feeding MARMUX/PCMUX, NZP condition codes, a BEN branch-enable register and bus-conflict detection.
- Driven cycle-by-cycle by the ISDU control FSM; memory interface unchanged (MDR_In/MIO_EN).

Parameters:
- DATA_W, 16, datapath/bus width (>=16); IR fields sign-extended to DATA_W.
- LED_W, 10, LED output width (<=16), sourced from IR[LED_W-1:0].
- PC_RESET, 0, PC value after reset.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- LD_REG, LD_PC, LD_MDR, LD_MAR, LD_IR, LD_LED, LD_CC, LD_BEN  in  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  in  1 each  bus drive selects.
- PCMUX  in  2  PC source select.
- ADDR2MUX  in  2  address adder operand-2 select.
- ALUK  in  2  ALU op select.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  in  1 each  operand/destination selects.
- MIO_EN  in  1  MDR source: 1 = MDR_In, 0 = bus.
- MDR_In  in  DATA_W  memory read data.
- IR, PC, MAR, MDR  out  DATA_W each  architectural registers.
- LED  out  LED_W  debug LEDs.
- NZP  out  3  condition codes {N,Z,P}.
- BEN  out  1  branch enable.
- bus_conflict  out  1  sticky multi-gate error flag.

Behaviour:
- Reset (async, active-high) forces: PC=PC_RESET; IR=MAR=MDR=0; R0..R7=0; NZP=000; BEN=0; LED=0; bus_conflict=0. Reset asserted mid-operation overrides all loads immediately.
- Bus (combinational), priority PC > MDR > ALU > MARMUX. No gate asserted -> bus = 0.
- Register file: DR = DRMUX ? 7 : IR[11:9]; SR1 = SR1MUX ? IR[8:6] : IR[11:9]; SR2 = IR[2:0]. Reads combinational; write on Clk edge when LD_REG, data = bus.
- Same-cycle read and write of the same register: the read returns the pre-edge value (no bypass).
- ALU operand B = SR2MUX ? sext(IR[4:0]) : R[SR2].
- ALUK: 00 A+B, 01 A&B, 10 ~A, 11 A. Modulo 2^DATA_W; carry discarded.
- Address adder = (ADDR1MUX ? R[SR1] : PC) + ADDR2, where ADDR2MUX selects: 00 -> 0, 01 -> sext(IR[5:0]), 10 -> sext(IR[8:0]), 11 -> sext(IR[10:0]). MARMUX = adder output.
- PCMUX: 00 PC+1, 01 bus, 10 adder, 11 hold PC. PC updates only when LD_PC.
- MAR <= bus on LD_MAR; IR <= bus on LD_IR; MDR <= (MIO_EN ? MDR_In : bus) on LD_MDR.
- All loads sample pre-edge values, e.g. GatePC+LD_MAR+LD_PC in one cycle: MAR gets old PC, PC gets PC+1.
- LD_CC: NZP <= bus[DATA_W-1] ? 100 : (bus==0 ? 010 : 001).
- LD_BEN: BEN <= |(IR[11:9] & NZP), using pre-edge NZP. LD_CC and LD_BEN in the same cycle use the old NZP.
- LED <= IR[LED_W-1:0] when LD_LED, else 0 (registered, one-cycle latency).
- PC+1 wraps from all-ones to 0.

Optional Feature:
- Macro SLC3_BUS_CONFLICT_EN.
- Defined: bus_conflict sets on any Clk edge where more than one Gate* is asserted; it stays set until Reset. Bus priority is unaffected.
- Undefined: bus_conflict tied to 0; no detection logic is synthesised.

Test Plan:
- Reset while PC=0x0042, R3=0x1234 -> PC=PC_RESET(0), R3=0, NZP=000, LED=0 immediately, without waiting for a clock edge.
- Fetch: PC=0x0005; GatePC+LD_MAR+LD_PC (PCMUX=00) -> MAR=0x0005, PC=0x0006; then MIO_EN+LD_MDR with MDR_In=0x1283 -> MDR=0x1283; then GateMDR+LD_IR -> IR=0x1283.
- ADD immediate: R2=0x7FFF, IR=0x1483 (R2 <- R2+3), SR1MUX=1, SR2MUX=1, GateALU+LD_REG+LD_CC -> R2=0x8002, NZP=100.
- Branch: NZP=010, IR=0x05FD (BRz -3) -> LD_BEN: BEN=1; ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC with PC=0x0010 -> PC=0x000D.
- Conflict: GatePC+GateMDR in one cycle, PC=0x0003, MDR=0x00FF, LD_MAR -> MAR=0x0003; bus_conflict=1 (macro on) and stays 1 until Reset; bus_conflict=0 with macro off.
- LED: IR=0x03FF with LD_LED -> LED=0x3FF next edge; LD_LED low -> LED=0 next edge.
